ramctrl: RTL

- Memory controller; the responder end of the icache↔ramctrl fetch interface. Also serves load/store requests from the load-store buffer (LSB).
- Arbitrates between the two requesters and serializes each 1/2/4-byte access onto the byte-wide synchronous RAM/IO bus.
- Returns a one-cycle ready pulse with the assembled word.
- Sits between icache/LSB and the top-level memory pins.

---
 rtl/ramctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ramctrl.sv
// ramctrl: arbitrates icache fetches and LSB loads/stores onto the byte-wide RAM/IO bus.
// Define RAMCTRL_RR_ARB_EN for round-robin arbitration instead of fixed LSB priority.
module ramctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_ADDR_BASE = 32'h30000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  icache_ramctrl_en_in,
    input  logic [ADDR_WIDTH-1:0] icache_ramctrl_addr_in,
    output logic                  ramctrl_icache_inst_rdy_out,
    output logic [DATA_WIDTH-1:0] ramctrl_icache_inst_inst_out,
    input  logic                  lsb_ramctrl_en_in,
    input  logic                  lsb_ramctrl_rw_in,
    input  logic [ADDR_WIDTH-1:0] lsb_ramctrl_addr_in,
    input  logic [1:0]            lsb_ramctrl_len_in,
    input  logic [DATA_WIDTH-1:0] lsb_ramctrl_data_in,
    output logic                  ramctrl_lsb_rdy_out,
    output logic [DATA_WIDTH-1:0] ramctrl_lsb_data_out,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t state, state_nx;
    logic src_lsb, src_nx, last_lsb, last_nx, gnt_lsb, fin;
    logic [ADDR_WIDTH-1:0] addr, addr_nx, mem_a_nx, cur_a;
    logic [1:0] nlen, nlen_nx, j;
    logic [2:0] k, k_nx;
    logic [DATA_WIDTH-1:0] data, data_nx, res, res_nx, ic_inst_nx, lsb_data_nx;
    logic mem_wr_nx, ic_rdy_nx, lsb_rdy_nx, was_act, sv_v;
    logic [7:0] mem_dout_nx, sv, din;

`ifdef RAMCTRL_RR_ARB_EN
    assign gnt_lsb = lsb_ramctrl_en_in && !(icache_ramctrl_en_in && last_lsb);
`else
    assign gnt_lsb = lsb_ramctrl_en_in;
`endif
    assign cur_a = addr + ADDR_WIDTH'(k);
    assign j = 2'(k - 3'd2);
    assign din = sv_v ? sv : mem_din;

    always_comb begin
        state_nx = state;
        src_nx = src_lsb;
        last_nx = last_lsb;
        addr_nx = addr;
        nlen_nx = nlen;
        data_nx = data;
        k_nx = k;
        res_nx = res;
        fin = 1'b0;
        mem_a_nx = '0;
        mem_wr_nx = 1'b0;
        mem_dout_nx = mem_dout;
        ic_rdy_nx = 1'b0;
        lsb_rdy_nx = 1'b0;
        ic_inst_nx = ramctrl_icache_inst_inst_out;
        lsb_data_nx = ramctrl_lsb_data_out;
        case (state)
            IDLE: if (gnt_lsb || icache_ramctrl_en_in) begin
                state_nx = gnt_lsb && lsb_ramctrl_rw_in ? WRITE : READ;
                src_nx = gnt_lsb;
                last_nx = gnt_lsb;
                addr_nx = gnt_lsb ? lsb_ramctrl_addr_in : icache_ramctrl_addr_in;
                nlen_nx = !gnt_lsb || lsb_ramctrl_len_in[1] ? 2'd3 : lsb_ramctrl_len_in;
                data_nx = lsb_ramctrl_data_in;
                k_nx = '0;
                res_nx = '0;
            end
            // byte j is issued at k = j and captured two edges later at k = j + 2
            READ: begin
                if (k <= {1'b0, nlen}) mem_a_nx = cur_a;
                if (k >= 3'd2) res_nx[{j, 3'b000} +: 8] = din;
                k_nx = k + 3'd1;
                fin = k == {1'b0, nlen} + 3'd2;
            end
            WRITE: begin
                if (k > {1'b0, nlen}) fin = 1'b1;
                else if (!(addr >= IO_ADDR_BASE && io_buffer_full)) begin
                    mem_a_nx = cur_a;
                    mem_dout_nx = data[{k[1:0], 3'b000} +: 8];
                    mem_wr_nx = 1'b1;
                    k_nx = k + 3'd1;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (fin) begin
            state_nx = DONE;
            ic_rdy_nx = !src_lsb;
            lsb_rdy_nx = src_lsb;
            ic_inst_nx = src_lsb ? ramctrl_icache_inst_inst_out : res_nx;
            lsb_data_nx = src_lsb ? res_nx : ramctrl_lsb_data_out;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            src_lsb <= 1'b0;
            last_lsb <= 1'b0;
            addr <= '0;
            nlen <= '0;
            data <= '0;
            k <= '0;
            res <= '0;
            mem_a <= '0;
            mem_wr <= 1'b0;
            mem_dout <= '0;
            ramctrl_icache_inst_rdy_out <= 1'b0;
            ramctrl_icache_inst_inst_out <= '0;
            ramctrl_lsb_rdy_out <= 1'b0;
            ramctrl_lsb_data_out <= '0;
        end else if (rdy_in) begin
            state <= state_nx;
            src_lsb <= src_nx;
            last_lsb <= last_nx;
            addr <= addr_nx;
            nlen <= nlen_nx;
            data <= data_nx;
            k <= k_nx;
            res <= res_nx;
            mem_a <= mem_a_nx;
            mem_wr <= mem_wr_nx;
            mem_dout <= mem_dout_nx;
            ramctrl_icache_inst_rdy_out <= ic_rdy_nx;
            ramctrl_icache_inst_inst_out <= ic_inst_nx;
            ramctrl_lsb_rdy_out <= lsb_rdy_nx;
            ramctrl_lsb_data_out <= lsb_data_nx;
        end
    end

    // RAM keeps returning data while frozen; keep the byte that was in flight when the freeze began
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            was_act <= 1'b0;
            sv_v <= 1'b0;
            sv <= '0;
        end else begin
            was_act <= rdy_in;
            if (!rdy_in && was_act) begin
                sv <= mem_din;
                sv_v <= 1'b1;
            end else if (rdy_in) sv_v <= 1'b0;
        end
    end
endmodule
